// File: rtl/fu_issue_scheduler_pkg.sv
// Shared payload layout for the reservation-station to functional-unit issue path.
package fu_issue_scheduler_pkg;

  localparam int ALUCTL_W  = 4;
  localparam int DATA_W    = 32;
  localparam int TAG_W     = 6;
  localparam int ROB_W     = 6;
  localparam int PAYLOAD_W = ALUCTL_W + 2 + 3 * DATA_W + TAG_W + ROB_W;

  localparam int ROB_LSB    = 0;
  localparam int TAG_LSB    = ROB_LSB + ROB_W;
  localparam int RS2_LSB    = TAG_LSB + TAG_W;
  localparam int RS1_LSB    = RS2_LSB + DATA_W;
  localparam int IMM_LSB    = RS1_LSB + DATA_W;
  localparam int LSQ_LSB    = IMM_LSB + DATA_W;
  localparam int SRC_LSB    = LSQ_LSB + 1;
  localparam int ALUCTL_LSB = SRC_LSB + 1;

  // FUs validate ALUControl every cycle, so an idle issue slot must carry this code.
  localparam logic [ALUCTL_W-1:0] ALU_NONE = 4'b0000;

  typedef struct packed {
    logic [ALUCTL_W-1:0] alu_ctl;
    logic                alu_src;
    logic                is_for_lsq;
    logic [DATA_W-1:0]   imm;
    logic [DATA_W-1:0]   rs1_value;
    logic [DATA_W-1:0]   rs2_value;
    logic [TAG_W-1:0]    tag;
    logic [ROB_W-1:0]    rob_index;
  } payload_t;

endpackage

// File: rtl/fu_issue_scheduler_rr_pick_n.sv
// Wrap-around priority scan: the k-th enabled pick takes the next unclaimed request found from ptr upward.
module rr_pick_n #(
  parameter  int NUM_REQ  = 8,
  parameter  int NUM_PICK = 3,
  localparam int PTR_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]                req,
  input  logic [PTR_W-1:0]                  ptr,
  input  logic [NUM_PICK-1:0]               pick_en,
  output logic [NUM_PICK-1:0][NUM_REQ-1:0]  pick_sel,
  output logic [NUM_PICK-1:0]               pick_valid,
  output logic [NUM_REQ-1:0]                granted,
  output logic [PTR_W-1:0]                  last_idx,
  output logic                              any_grant
);

  logic [PTR_W-1:0] idx;
  logic             found;

  // Later picks always land later in scan order, so the final assignment to last_idx is the last grant.
  always_comb begin
    pick_sel   = '0;
    pick_valid = '0;
    granted    = '0;
    last_idx   = ptr;
    any_grant  = 1'b0;
    idx        = '0;
    found      = 1'b0;
    for (int k = 0; k < NUM_PICK; k++) begin
      found = 1'b0;
      if (pick_en[k]) begin
        for (int o = 0; o < NUM_REQ; o++) begin
          idx = ptr + PTR_W'(o);
          if (!found && req[idx] && !granted[idx]) begin
            found            = 1'b1;
            granted[idx]     = 1'b1;
            pick_sel[k][idx] = 1'b1;
            pick_valid[k]    = 1'b1;
            last_idx         = idx;
            any_grant        = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/fu_issue_scheduler.sv
// Selects ready reservation-station slots, pairs them round-robin with free FUs and drives each FU from a register.
module fu_issue_scheduler
  import fu_issue_scheduler_pkg::*;
#(
  parameter  int NUM_REQ = 8,
  parameter  int NUM_FU  = 3,
  localparam int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          flush,
  input  logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*PAYLOAD_W-1:0]  req_payload,
  output logic [NUM_REQ-1:0]            req_ack,
  input  logic [NUM_FU-1:0]             fu_available,
  output logic [NUM_FU-1:0]             fu_write_enable,
  output logic [NUM_FU*ALUCTL_W-1:0]    fu_ALUControl,
  output logic [NUM_FU-1:0]             fu_ALUSrc,
  output logic [NUM_FU-1:0]             fu_is_for_lsq,
  output logic [NUM_FU*DATA_W-1:0]      fu_imm,
  output logic [NUM_FU*DATA_W-1:0]      fu_rs1_value,
  output logic [NUM_FU*DATA_W-1:0]      fu_rs2_value,
  output logic [NUM_FU*TAG_W-1:0]       fu_tag,
  output logic [NUM_FU*ROB_W-1:0]       fu_rob_index
);

  logic [PTR_W-1:0]                rr_ptr;
  logic [PTR_W-1:0]                last_idx;
  logic                            any_grant;
  logic [NUM_FU-1:0]               we_q;
  logic [NUM_FU-1:0]               inflight;
  logic [NUM_FU-1:0]               fu_elig;
  logic [NUM_FU-1:0]               pick_valid;
  logic [NUM_FU-1:0][NUM_REQ-1:0]  pick_sel;
  logic [NUM_REQ-1:0]              req_elig;
  logic [NUM_REQ-1:0]              granted;
  payload_t                        slot_pl [NUM_REQ];
  payload_t                        pick_pl [NUM_FU];
  payload_t                        issue_q [NUM_FU];

  // An FU's is_available lags our write by a cycle, so the registered write enable doubles as its busy mask.
  assign inflight = we_q;
  assign req_elig = req_ready & {NUM_REQ{~flush & reset_n}};
  assign fu_elig  = fu_available & ~inflight & {NUM_FU{~flush & reset_n}};
  assign req_ack  = granted;

  rr_pick_n #(
    .NUM_REQ  (NUM_REQ),
    .NUM_PICK (NUM_FU)
  ) u_pick (
    .req        (req_elig),
    .ptr        (rr_ptr),
    .pick_en    (fu_elig),
    .pick_sel   (pick_sel),
    .pick_valid (pick_valid),
    .granted    (granted),
    .last_idx   (last_idx),
    .any_grant  (any_grant)
  );

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
    assign slot_pl[i] = payload_t'(req_payload[PAYLOAD_W*i +: PAYLOAD_W]);
  end

  always_comb begin
    for (int k = 0; k < NUM_FU; k++) begin
      pick_pl[k] = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (pick_sel[k][i]) pick_pl[k] = slot_pl[i];
      end
    end
  end

  // Unpaired FUs only get their write enable and ALUControl cleared; operand fields keep their last value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      we_q   <= '0;
      rr_ptr <= '0;
      for (int k = 0; k < NUM_FU; k++) issue_q[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_FU; k++) begin
        if (pick_valid[k]) begin
          issue_q[k] <= pick_pl[k];
          we_q[k]    <= 1'b1;
        end else begin
          issue_q[k].alu_ctl <= ALU_NONE;
          we_q[k]            <= 1'b0;
        end
      end
      if (any_grant) rr_ptr <= last_idx + PTR_W'(1);
    end
  end

  assign fu_write_enable = we_q;

  for (genvar k = 0; k < NUM_FU; k++) begin : g_fu
    assign fu_ALUControl[ALUCTL_W*k +: ALUCTL_W] = issue_q[k].alu_ctl;
    assign fu_ALUSrc[k]                          = issue_q[k].alu_src;
    assign fu_is_for_lsq[k]                      = issue_q[k].is_for_lsq;
    assign fu_imm[DATA_W*k +: DATA_W]            = issue_q[k].imm;
    assign fu_rs1_value[DATA_W*k +: DATA_W]      = issue_q[k].rs1_value;
    assign fu_rs2_value[DATA_W*k +: DATA_W]      = issue_q[k].rs2_value;
    assign fu_tag[TAG_W*k +: TAG_W]              = issue_q[k].tag;
    assign fu_rob_index[ROB_W*k +: ROB_W]        = issue_q[k].rob_index;
  end

  fu_we_requires_available: assert property (
    @(posedge clk) disable iff (!reset_n) ((we_q & ~fu_available) == '0)
  ) else $fatal(1, "fu_write_enable high on an unavailable FU");

endmodule

// File: doc/fu_issue_scheduler.md
Name: fu_issue_scheduler

Overview:
- Sits between the reservation station and a pool of identical functional units (FUs).
- Each cycle it selects up to NUM_FU ready reservation-station slots and assigns them round-robin to available FUs.
- It acknowledges the selected slots and drives each FU's issue interface from a registered stage.
- It masks an FU while an issue to it is in flight, so an FU never sees a write while unavailable.

Parameters:
NUM_REQ, 8, number of reservation-station slots (requesters); power of two, 2..16
NUM_FU, 3, number of functional units; 1..4
PTR_W, $clog2(NUM_REQ), round-robin pointer width (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
flush  in  1  synchronous; discard the in-flight issue stage and grant nothing this cycle
req_ready  in  NUM_REQ  slot i holds an instruction with all operands ready
req_payload  in  NUM_REQ*114  slot i bits [114*i +: 114] = {ALUControl[4], ALUSrc, is_for_lsq, imm[32], rs1_value[32], rs2_value[32], tag[6], rob_index[6]}, MSB first
req_ack  out  NUM_REQ  one-cycle pulse: slot i granted; the reservation station frees it at this edge
fu_available  in  NUM_FU  is_available from each FU
fu_write_enable  out  NUM_FU  write_enable to each FU
fu_ALUControl  out  NUM_FU*4  per-FU ALUControl
fu_ALUSrc  out  NUM_FU  per-FU ALUSrc
fu_is_for_lsq  out  NUM_FU  per-FU is_for_lsq
fu_imm, fu_rs1_value, fu_rs2_value  out  NUM_FU*32 each  per-FU operands
fu_tag  out  NUM_FU*6  per-FU tag_to_output
fu_rob_index  out  NUM_FU*6  per-FU rob_index

Behaviour:
- Reset (reset_n low, asynchronous):
  - rr_ptr=0, inflight=0.
  - All fu_write_enable=0; fu_ALUControl=4'b0000; all other fu_* fields=0.
  - req_ack=0 combinationally (forced by inflight=0 plus the reset qualifier).
- Eligible FU k in cycle t: fu_available[k] && !inflight[k] && !flush.
- Eligible slot i: req_ready[i] && !flush.
- Grant (combinational, cycle t):
  - Scan slots from rr_ptr upward with wrap modulo NUM_REQ.
  - Pair the j-th eligible slot found with the j-th eligible FU in ascending FU index.
  - Stop when either list is exhausted.
  - req_ack[i]=1 for each paired slot.
- Issue register (edge end of t): for each paired FU k, load its fu_* fields from the paired slot's payload, set fu_write_enable[k]=1, set inflight[k]=1.
- Unpaired FU k at the same edge: fu_write_enable[k]=0, inflight[k]=0, fu_ALUControl[k]=4'b0000. Other fields hold.
- Latency: ack in cycle t; the FU latches at the end of t+1. Total slot-to-FU latency is 2 edges.
- inflight[k] is exactly the registered fu_write_enable[k]. The FU is masked during t+1 because its is_available has not yet reflected the write. No back-to-back issue to the same FU.
- Idle fu_ALUControl must be 4'b0000: the FU checks ALUControl validity every cycle.
- rr_ptr update: if any grant, rr_ptr <= (index of last granted slot + 1) mod NUM_REQ; otherwise it holds.
- Boundary conditions:
  - No ready slots or no eligible FUs: no ack, rr_ptr holds.
  - More ready slots than FUs: the surplus waits; fairness comes from rr_ptr.
  - Pointer wrap: rr_ptr=NUM_REQ-1 with grant of slot 1 sets rr_ptr=2.
  - flush: zero acks that cycle; all fu_write_enable and inflight cleared at the edge; ALUControl driven to 0000; rr_ptr holds.
  - Reset mid-issue: the pending write is dropped (fu_write_enable=0 immediately).
- Payload is passed through unmodified; no arithmetic is performed on it.
- Simulation assertion: fatal if fu_write_enable[k] is high while fu_available[k] is low.

Decomposition:
- Shared package/header: payload field widths and offsets (ALUCTL_W=4, DATA_W=32, TAG_W=6, ROB_W=6, PAYLOAD_W=114, field LSB constants) and ALU_NONE=4'b0000.
- One sub-module: rr_pick_n. Combinational wrap-around priority scan that returns up to NUM_FU one-hot slot selects plus the last-granted index. It is reused by the later LSQ port scheduler.

Test Plan:
- Reset: reset_n=0 mid-cycle -> all fu_write_enable=0 and fu_ALUControl=0000 asynchronously; req_ack=0.
- Single issue: req_ready=8'b0000_0100 with ADD payload (ALUControl=0010, rs1=5, imm=7, ALUSrc=1, tag=9), all FUs available -> cycle t: req_ack=0000_0100; t+1: fu_write_enable=001 with FU0 fields equal to the payload; rr_ptr=3.
- Oversubscription: req_ready=8'hFF, rr_ptr=6, 3 FUs available -> acks for slots 6, 7, 0 mapped to FUs 0, 1, 2; rr_ptr=1. Next cycle: FUs masked by inflight -> zero acks.
- Partial FUs: fu_available=3'b101, req_ready=8'b0000_0011 -> slot0->FU0, slot1->FU2; fu_write_enable=101 next cycle.
- Flush: req_ready=8'h01 with flush=1 -> no ack. With an issue pending in the register and flush asserted -> next edge fu_write_enable=000, ALUControl=0000.
- Fairness: slots 0 and 5 permanently ready, NUM_FU=1, FU available every other cycle -> grants alternate 0, 5, 0, 5; no slot waits more than 2 grant opportunities.
